// File: rtl/eer_pkt_pkg.sv
// Shared packet definitions for the EER receive path: type codes, per-type
// byte lengths and parser FSM encodings.
package eer_pkt_pkg;

   localparam logic [2:0] PKT_HB   = 3'b000;
   localparam logic [2:0] PKT_CHE  = 3'b001;
   localparam logic [2:0] PKT_TS   = 3'b100;
   localparam logic [2:0] PKT_DATA = 3'b101;

   localparam logic [3:0] LEN_HB   = 4'd11;
   localparam logic [3:0] LEN_CHE  = 4'd3;
   localparam logic [3:0] LEN_TS   = 4'd5;
   localparam logic [3:0] LEN_DATA = 4'd5;

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StBody,
      StDrop,
      StCommit
   } pfe_state_e;

   // Zero length marks a type the parser consumes but never commits.
   function automatic logic [3:0] pkt_len(input logic [2:0] t);
      case (t)
         PKT_HB:   return LEN_HB;
         PKT_CHE:  return LEN_CHE;
         PKT_TS:   return LEN_TS;
         PKT_DATA: return LEN_DATA;
         default:  return 4'd0;
      endcase
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/pkt_field_extract.sv
// Byte-serial packet parser: decodes type, assembles big-endian 16-bit fields,
// filters, and commits them to the node-info block with a one-cycle en_MNI strobe.
module pkt_field_extract
   import eer_pkt_pkg::*;
#(
   parameter logic [15:0] MY_NODE_ID = 16'h000C,
   parameter int unsigned WORD_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  rx_valid,
   input  logic                  rx_sop,
   input  logic                  rx_eop,
   input  logic [7:0]            rx_byte,
   output logic                  rx_ready,
   output logic [2:0]            fPktType,
   output logic [WORD_WIDTH-1:0] hops,
   output logic [WORD_WIDTH-1:0] e_max,
   output logic [WORD_WIDTH-1:0] e_min,
   output logic [WORD_WIDTH-1:0] e_threshold,
   output logic [WORD_WIDTH-1:0] ch_ID,
   output logic [WORD_WIDTH-1:0] timeslot,
   output logic                  en_MNI,
   output logic                  pkt_err
);

   pfe_state_e            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d, len_q, len_d;
   logic [2:0]            type_q, type_d;
   logic                  drop_err_q, drop_err_d;
   logic [7:0]            hi_q, hi_d;
   logic [WORD_WIDTH-1:0] sh_q [5];
   logic [WORD_WIDTH-1:0] sh_d [5];
   logic                  accept, body_byte, start_hdr, commit_go, err_go;
   logic [3:0]            cnt_inc;
   logic [2:0]            hdr_type, widx;

   assign accept    = rx_valid & rx_ready;
   assign cnt_inc   = cnt_q + 4'd1;
   assign hdr_type  = rx_byte[7:5];
   assign body_byte = accept & ~rx_sop & ((state_q == StHdr) | (state_q == StBody));
   assign widx      = cnt_q[3:1] - 3'd1;

   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) state_q <= StIdle;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      type_d     = type_q;
      len_d      = len_q;
      drop_err_d = drop_err_q;
      start_hdr  = 1'b0;
      commit_go  = 1'b0;
      err_go     = 1'b0;
      unique case (state_q)
         StIdle: start_hdr = accept & rx_sop;
         StHdr, StBody: begin
            if (accept) begin
               if (rx_sop) begin
                  err_go    = 1'b1;
                  start_hdr = 1'b1;
               end else if (rx_eop) begin
                  state_d = StIdle;
                  if (cnt_inc != len_q) begin
                     err_go = 1'b1;
                  end else if (type_q != PKT_TS || sh_q[0] == MY_NODE_ID) begin
                     commit_go = 1'b1;
                     state_d   = StCommit;
                  end
               end else if (cnt_inc == len_q) begin
                  // Full length seen without eop; flag the overrun on the next byte.
                  state_d    = StDrop;
                  drop_err_d = 1'b1;
               end else begin
                  state_d = StBody;
                  cnt_d   = cnt_inc;
               end
            end
         end
         StDrop: begin
            if (accept) begin
               if (rx_sop) begin
                  err_go    = 1'b1;
                  start_hdr = 1'b1;
               end else begin
                  if (drop_err_q) begin
                     err_go     = 1'b1;
                     drop_err_d = 1'b0;
                  end
                  if (rx_eop) state_d = StIdle;
               end
            end
         end
         StCommit: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
      if (start_hdr) begin
         type_d     = hdr_type;
         len_d      = pkt_len(hdr_type);
         cnt_d      = 4'd1;
         drop_err_d = 1'b0;
         if (pkt_len(hdr_type) == 4'd0) begin
            state_d = rx_eop ? StIdle : StDrop;
         end else if (rx_eop) begin
            state_d = StIdle;
            err_go  = 1'b1;
         end else begin
            state_d = StHdr;
         end
      end
   end

   always_comb begin
      rx_ready = (state_q != StCommit);
   end

   // Odd byte index holds a high byte, even index completes word (index/2 - 1).
   always_comb begin
      hi_d = hi_q;
      sh_d = sh_q;
      if (body_byte) begin
         if (cnt_q[0])          hi_d = rx_byte;
         else if (widx < 3'd5)  sh_d[widx] = {hi_q, rx_byte};
      end
   end

   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         cnt_q       <= 4'd0;
         len_q       <= 4'd0;
         type_q      <= 3'd0;
         drop_err_q  <= 1'b0;
         hi_q        <= 8'd0;
         for (int i = 0; i < 5; i++) sh_q[i] <= '0;
         fPktType    <= 3'b111;
         hops        <= '0;
         e_max       <= '0;
         e_min       <= '0;
         e_threshold <= '0;
         ch_ID       <= '0;
         timeslot    <= '0;
         en_MNI      <= 1'b0;
         pkt_err     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         type_q     <= type_d;
         drop_err_q <= drop_err_d;
         hi_q       <= hi_d;
         sh_q       <= sh_d;
         en_MNI     <= commit_go;
         pkt_err    <= err_go;
         if (commit_go) begin
            fPktType <= type_q;
            case (type_q)
               PKT_HB: begin
                  hops        <= sat_inc(sh_d[1]);
                  e_max       <= sh_d[2];
                  e_min       <= sh_d[3];
                  e_threshold <= sh_d[4];
               end
               PKT_CHE: ch_ID    <= sh_d[0];
               PKT_TS:  timeslot <= sh_d[1];
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pkt_field_extract.sv
// Scoreboard bench for pkt_field_extract: expected strobes and output snapshots
// are queued as packets are driven and popped when en_MNI or pkt_err fires.
module tb_pkt_field_extract;

   typedef struct {
      logic [2:0]  t;
      logic [15:0] hops, emax, emin, ethr, ch, ts;
   } out_t;

   typedef struct {
      bit   commit;
      int   cyc;
      out_t o;
   } evt_t;

   logic        clk = 1'b0;
   logic        nrst;
   logic        rx_valid, rx_sop, rx_eop, rx_ready;
   logic [7:0]  rx_byte;
   logic [2:0]  fPktType;
   logic [15:0] hops, e_max, e_min, e_threshold, ch_ID, timeslot;
   logic        en_MNI, pkt_err;

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   last_cyc, first_cyc, che_last;
   logic [7:0] pkt[$];
   evt_t sb[$];
   out_t mdl;

   pkt_field_extract #(.MY_NODE_ID(16'h000C), .WORD_WIDTH(16)) dut (
      .clk(clk), .nrst(nrst), .rx_valid(rx_valid), .rx_sop(rx_sop), .rx_eop(rx_eop),
      .rx_byte(rx_byte), .rx_ready(rx_ready), .fPktType(fPktType), .hops(hops),
      .e_max(e_max), .e_min(e_min), .e_threshold(e_threshold), .ch_ID(ch_ID),
      .timeslot(timeslot), .en_MNI(en_MNI), .pkt_err(pkt_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic chk_outs(input string tag, input out_t o);
      chk({tag, ".type"}, fPktType, o.t);
      chk({tag, ".hops"}, hops, o.hops);
      chk({tag, ".e_max"}, e_max, o.emax);
      chk({tag, ".e_min"}, e_min, o.emin);
      chk({tag, ".e_thr"}, e_threshold, o.ethr);
      chk({tag, ".ch_ID"}, ch_ID, o.ch);
      chk({tag, ".timeslot"}, timeslot, o.ts);
   endtask

   task automatic reset_model();
      mdl = '{t: 3'b111, hops: 16'd0, emax: 16'd0, emin: 16'd0, ethr: 16'd0,
              ch: 16'd0, ts: 16'd0};
   endtask

   task automatic push(input bit commit);
      evt_t e;
      e.commit = commit;
      e.cyc    = last_cyc + 1;
      e.o      = mdl;
      sb.push_back(e);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic sop, input logic eop);
      int   n = 0;
      logic done = 1'b0;
      rx_valid = 1'b1; rx_byte = b; rx_sop = sop; rx_eop = eop;
      while (!done) begin
         done     = rx_ready;
         last_cyc = cyc;
         @(posedge clk); #1;
         n++;
         if (n > 8 && !done) begin
            chk("ready_timeout", 32'd0, 32'd1);
            done = 1'b1;
         end
      end
      rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
   endtask

   task automatic send_pkt(input int eop_at);
      for (int i = 0; i < pkt.size(); i++) begin
         send_byte(pkt[i], i == 0, i == eop_at);
         if (i == 0) first_cyc = last_cyc;
      end
   endtask

   task automatic gap_and_check(input string tag);
      repeat (3) @(posedge clk);
      #1;
      chk_outs(tag, mdl);
   endtask

   always @(negedge clk) begin
      if (!nrst && (en_MNI || pkt_err)) begin
         evt_t e;
         chk("strobes_exclusive", {31'd0, en_MNI & pkt_err}, 32'd0);
         if (sb.size() == 0) begin
            chk("unexpected_strobe", {30'd0, en_MNI, pkt_err}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("strobe_kind", {30'd0, en_MNI, pkt_err}, e.commit ? 32'd2 : 32'd1);
            chk("strobe_cycle", cyc, e.cyc);
            if (e.commit) chk("ready_in_commit", {31'd0, rx_ready}, 32'd0);
            chk_outs("evt", e.o);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      nrst = 1'b1; rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_byte = 8'h00;
      reset_model();
      repeat (2) @(posedge clk);
      #1;
      chk_outs("reset", mdl);
      chk("reset.rx_ready", {31'd0, rx_ready}, 32'd1);
      chk("reset.strobes", {30'd0, en_MNI, pkt_err}, 32'd0);
      nrst = 1'b0;
      @(posedge clk); #1;

      // Stray bytes in idle are discarded silently.
      send_byte(8'h20, 1'b0, 1'b0);
      send_byte(8'h0C, 1'b0, 1'b1);

      pkt = '{8'h00, 8'h00, 8'h07, 8'h00, 8'h02, 8'h03, 8'hE8, 8'h00, 8'h64, 8'h01, 8'hF4};
      send_pkt(10);
      mdl.t = 3'b000; mdl.hops = 16'd3; mdl.emax = 16'd1000; mdl.emin = 16'd100;
      mdl.ethr = 16'd500;
      push(1'b1);
      gap_and_check("hb");

      pkt = '{8'h80, 8'h00, 8'h0C, 8'h00, 8'h05};
      send_pkt(4);
      mdl.t = 3'b100; mdl.ts = 16'd5;
      push(1'b1);
      gap_and_check("ts_mine");

      pkt = '{8'h80, 8'h00, 8'h0D, 8'h00, 8'h09};
      send_pkt(4);
      gap_and_check("ts_other");

      pkt = '{8'h20, 8'h00, 8'h0C};
      send_pkt(2);
      che_last = last_cyc;
      mdl.t = 3'b001; mdl.ch = 16'd12;
      push(1'b1);
      pkt = '{8'hA0, 8'h00, 8'h01, 8'h00, 8'h0C};
      send_pkt(4);
      chk("b2b_sop_cycle", first_cyc, che_last + 2);
      mdl.t = 3'b101;
      push(1'b1);
      gap_and_check("data");

      pkt = '{8'h00, 8'h00, 8'h07, 8'h00, 8'h02, 8'h03};
      send_pkt(5);
      push(1'b0);
      gap_and_check("hb_short");

      pkt = '{8'h20, 8'h00, 8'h0D, 8'h55};
      send_pkt(3);
      push(1'b0);
      gap_and_check("che_long");

      pkt = '{8'h20};
      send_pkt(0);
      push(1'b0);
      gap_and_check("single_byte");

      pkt = '{8'h00, 8'h00, 8'h07, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
      send_pkt(10);
      mdl.t = 3'b000; mdl.hops = 16'hFFFF; mdl.emax = 16'd1; mdl.emin = 16'd2;
      mdl.ethr = 16'd3;
      push(1'b1);
      gap_and_check("hb_sat");

      pkt = '{8'h40, 8'h11, 8'h22, 8'h33};
      send_pkt(3);
      gap_and_check("ignored");

      // Reset while byte 5 of a heartbeat is on the bus.
      pkt = '{8'h00, 8'h00, 8'h07, 8'h00};
      send_pkt(-1);
      rx_valid = 1'b1; rx_byte = 8'h05;
      #2 nrst = 1'b1;
      #1;
      reset_model();
      chk_outs("mid_reset", mdl);
      chk("mid_reset.rx_ready", {31'd0, rx_ready}, 32'd1);
      rx_valid = 1'b0;
      @(posedge clk); #1;
      nrst = 1'b0;
      @(posedge clk); #1;
      pkt = '{8'h20, 8'h00, 8'h0C};
      send_pkt(2);
      mdl.t = 3'b001; mdl.ch = 16'd12;
      push(1'b1);
      gap_and_check("che_after_reset");

      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
